// File: rtl/branch_predictor.sv
// Next-PC predictor: direct-mapped BTB with 2-bit saturating counters,
// trained by resolved branches from execute, bulk-invalidated by ctrl.
module branch_predictor #(
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned IDX_W     = $clog2(ENTRIES),
  parameter logic [1:0]  RESET_CTR = 2'b10
) (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic [31:0] pc_i,
  output logic [31:0] next_pc_o,
  output logic        next_taken_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  input  logic        invalidate_i,
  output logic [15:0] mispredict_cnt_o
);

  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  if (IDX_W != $clog2(ENTRIES) || ENTRIES < 4 || ENTRIES > 256
      || (1 << IDX_W) != ENTRIES) begin : g_bad_cfg
    $error("branch_predictor: inconsistent ENTRIES/IDX_W");
  end

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [29:0]        tgt_q [ENTRIES];
  logic [15:0]        cnt_q, cnt_d;

  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic             l_hit;

  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic [29:0]      u_tgt;
  logic             u_hit;
  logic             u_pred;
  logic             u_mis;
  logic [1:0]       u_ctr_d;
  logic             upd_en;

  logic unused_ok;
  assign unused_ok = ^{pc_i[1:0], upd_pc_i[1:0], upd_target_i[1:0]};

  // Lookup uses only registered state: no bypass from a same-cycle update.
  always_comb begin
    l_idx        = pc_i[IDX_W+1:2];
    l_tag        = pc_i[31:IDX_W+2];
    l_hit        = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    next_pc_o    = pc_i + 32'd4;
    next_taken_o = 1'b0;
    if (l_hit && ctr_q[l_idx][1]) begin
      next_pc_o    = {tgt_q[l_idx], 2'b00};
      next_taken_o = 1'b1;
    end
  end

  always_comb begin
    u_idx  = upd_pc_i[IDX_W+1:2];
    u_tag  = upd_pc_i[31:IDX_W+2];
    u_tgt  = upd_target_i[31:2];
    u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    u_pred = u_hit && ctr_q[u_idx][1];
    u_mis  = (u_pred != upd_taken_i)
          || (u_pred && upd_taken_i && (tgt_q[u_idx] != u_tgt));
    upd_en = upd_valid_i && !invalidate_i;
    u_ctr_d = ctr_q[u_idx];
    if (!u_hit) begin
      u_ctr_d = RESET_CTR;
    end else if (upd_taken_i) begin
      if (ctr_q[u_idx] != 2'b11) u_ctr_d = ctr_q[u_idx] + 2'd1;
    end else begin
      if (ctr_q[u_idx] != 2'b00) u_ctr_d = ctr_q[u_idx] - 2'd1;
    end
    cnt_d = cnt_q;
    if (upd_en && u_mis && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) ctr_q[i] <= 2'b01;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (invalidate_i) begin
        valid_q <= '0;
      end else if (upd_valid_i && (u_hit || upd_taken_i)) begin
        valid_q[u_idx] <= 1'b1;
        ctr_q[u_idx]   <= u_ctr_d;
      end
    end
  end

  // Tag/target payload needs no reset; it is only observed behind valid.
  always_ff @(posedge clk_i) begin
    if (upd_en && upd_taken_i) begin
      tag_q[u_idx] <= u_tag;
      tgt_q[u_idx] <= u_tgt;
    end
  end

  assign mispredict_cnt_o = cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus random training
// checked against an array-based model of the BTB.
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        n_rst_i;
  logic [31:0] pc_i;
  logic [31:0] next_pc_o;
  logic        next_taken_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        invalidate_i;
  logic [15:0] mispredict_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int          m_cnt;

  branch_predictor dut (
    .clk_i(clk_i), .n_rst_i(n_rst_i), .pc_i(pc_i),
    .next_pc_o(next_pc_o), .next_taken_o(next_taken_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i),
    .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i),
    .invalidate_i(invalidate_i), .mispredict_cnt_o(mispredict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == pc / 64);
  endfunction

  function automatic bit m_taken(logic [31:0] pc);
    return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_next(logic [31:0] pc);
    logic [31:0] r;
    r = pc + 32'd4;
    if (m_taken(pc)) r = m_tgt[idx_of(pc)];
    return r;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 1;
    end
    m_cnt = 0;
  endtask

  task automatic m_step();
    int  i;
    bit  hit;
    bit  pt;
    i   = idx_of(upd_pc_i);
    hit = m_hit(upd_pc_i);
    pt  = m_taken(upd_pc_i);
    if (invalidate_i) begin
      for (int k = 0; k < 16; k++) m_valid[k] = 0;
    end else if (upd_valid_i) begin
      if (pt != upd_taken_i || (pt && upd_taken_i && m_tgt[i] != upd_target_i))
        if (m_cnt < 65535) m_cnt++;
      if (hit) begin
        if (upd_taken_i) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = upd_target_i;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (upd_taken_i) begin
        m_valid[i] = 1;
        m_tag[i]   = upd_pc_i / 64;
        m_tgt[i]   = upd_target_i;
        m_ctr[i]   = 2;
      end
    end
  endtask

  task automatic cycle();
    m_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic upd(bit v, logic [31:0] pc, bit t, logic [31:0] tgt);
    upd_valid_i  = v;
    upd_pc_i     = pc;
    upd_taken_i  = t;
    upd_target_i = tgt;
  endtask

  task automatic do_reset();
    n_rst_i = 1'b0;
    m_reset();
    #2;
    n_rst_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    n_rst_i = 1'b0;
    pc_i = 32'h8000_0000;
    upd(0, 0, 0, 0);
    invalidate_i = 0;
    m_reset();
    #1;
    n_cmp++;
    if (next_pc_o !== 32'h8000_0004) begin
      n_bad++;
      $display("FAIL reset_pc got %h want 80000004", next_pc_o);
    end
    n_cmp++;
    if (next_taken_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_taken got %b want 0", next_taken_o);
    end
    n_cmp++;
    if (mispredict_cnt_o !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_cnt got %0d want 0", mispredict_cnt_o);
    end
    @(posedge clk_i);
    #1;
    n_rst_i = 1'b1;
  endtask

  task automatic test_train();
    do_reset();
    upd(1, 32'h8000_0010, 1, 32'h8000_0100);
    cycle();
    upd(0, 0, 0, 0);
    pc_i = 32'h8000_0010;
    #1;
    n_cmp++;
    if (next_pc_o !== 32'h8000_0100 || next_taken_o !== 1'b1) begin
      n_bad++;
      $display("FAIL train_lookup got %h/%b want 80000100/1",
               next_pc_o, next_taken_o);
    end
    n_cmp++;
    if (mispredict_cnt_o !== 16'd1) begin
      n_bad++;
      $display("FAIL train_cnt got %0d want 1", mispredict_cnt_o);
    end
  endtask

  task automatic test_not_taken();
    upd(1, 32'h8000_0010, 0, 32'h0);
    cycle();
    upd(0, 0, 0, 0);
    #1;
    n_cmp++;
    if (next_pc_o !== 32'h8000_0014 || next_taken_o !== 1'b0
        || mispredict_cnt_o !== 16'd2) begin
      n_bad++;
      $display("FAIL nt_first got %h/%b/%0d want 80000014/0/2",
               next_pc_o, next_taken_o, mispredict_cnt_o);
    end
    upd(1, 32'h8000_0010, 0, 32'h0);
    cycle();
    upd(0, 0, 0, 0);
    #1;
    n_cmp++;
    if (mispredict_cnt_o !== 16'd2) begin
      n_bad++;
      $display("FAIL nt_second_cnt got %0d want 2", mispredict_cnt_o);
    end
    upd(1, 32'h8000_0010, 1, 32'h8000_0100);
    cycle();
    upd(0, 0, 0, 0);
    #1;
    n_cmp++;
    if (next_pc_o !== 32'h8000_0014 || next_taken_o !== 1'b0
        || mispredict_cnt_o !== 16'd3) begin
      n_bad++;
      $display("FAIL nt_retake got %h/%b/%0d want 80000014/0/3",
               next_pc_o, next_taken_o, mispredict_cnt_o);
    end
  endtask

  task automatic test_alias();
    do_reset();
    upd(1, 32'h8000_0010, 1, 32'h8000_0100);
    cycle();
    upd(0, 0, 0, 0);
    pc_i = 32'h8000_0050;
    #1;
    n_cmp++;
    if (next_pc_o !== 32'h8000_0054 || next_taken_o !== 1'b0) begin
      n_bad++;
      $display("FAIL alias_miss got %h/%b want 80000054/0",
               next_pc_o, next_taken_o);
    end
    upd(1, 32'h8000_0050, 1, 32'h8000_0200);
    cycle();
    upd(0, 0, 0, 0);
    #1;
    n_cmp++;
    if (next_pc_o !== 32'h8000_0200 || next_taken_o !== 1'b1) begin
      n_bad++;
      $display("FAIL alias_replace got %h/%b want 80000200/1",
               next_pc_o, next_taken_o);
    end
    pc_i = 32'h8000_0010;
    #1;
    n_cmp++;
    if (next_pc_o !== 32'h8000_0014 || next_taken_o !== 1'b0
        || mispredict_cnt_o !== 16'd2) begin
      n_bad++;
      $display("FAIL alias_evicted got %h/%b/%0d want 80000014/0/2",
               next_pc_o, next_taken_o, mispredict_cnt_o);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    upd(1, 32'h8000_0010, 1, 32'h8000_0100);
    cycle();
    upd(1, 32'h8000_0020, 1, 32'h8000_0300);
    invalidate_i = 1;
    cycle();
    invalidate_i = 0;
    upd(0, 0, 0, 0);
    pc_i = 32'h8000_0010;
    #1;
    n_cmp++;
    if (next_pc_o !== 32'h8000_0014 || next_taken_o !== 1'b0) begin
      n_bad++;
      $display("FAIL inval_old got %h/%b want 80000014/0",
               next_pc_o, next_taken_o);
    end
    pc_i = 32'h8000_0020;
    #1;
    n_cmp++;
    if (next_pc_o !== 32'h8000_0024 || next_taken_o !== 1'b0
        || mispredict_cnt_o !== 16'd1) begin
      n_bad++;
      $display("FAIL inval_drop got %h/%b/%0d want 80000024/0/1",
               next_pc_o, next_taken_o, mispredict_cnt_o);
    end
    pc_i = 32'h8000_0030;
    upd(1, 32'h8000_0030, 1, 32'h8000_0400);
    #1;
    n_cmp++;
    if (next_pc_o !== 32'h8000_0034 || next_taken_o !== 1'b0) begin
      n_bad++;
      $display("FAIL no_bypass got %h/%b want 80000034/0",
               next_pc_o, next_taken_o);
    end
    cycle();
    upd(0, 0, 0, 0);
    #1;
    n_cmp++;
    if (next_pc_o !== 32'h8000_0400 || next_taken_o !== 1'b1) begin
      n_bad++;
      $display("FAIL post_update got %h/%b want 80000400/1",
               next_pc_o, next_taken_o);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    pc_i = 32'hFFFF_FFFC;
    #1;
    n_cmp++;
    if (next_pc_o !== 32'h0000_0000 || next_taken_o !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap got %h/%b want 00000000/0",
               next_pc_o, next_taken_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] ep;
    bit          et;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 19) == 0) pc_i = 32'hFFFF_FFFC;
      else pc_i = 32'h8000_0000 + 32'($urandom_range(0, 15) * 4)
                + 32'($urandom_range(0, 2) * 64);
      upd($urandom_range(0, 9) < 7,
          32'h8000_0000 + 32'($urandom_range(0, 15) * 4)
            + 32'($urandom_range(0, 2) * 64),
          $urandom_range(0, 1) == 1,
          32'h1000_0000 + 32'($urandom_range(0, 3) * 16'h40));
      invalidate_i = ($urandom_range(0, 39) == 0);
      #1;
      ep = m_next(pc_i);
      et = m_taken(pc_i);
      n_cmp++;
      if (next_pc_o !== ep || next_taken_o !== et) begin
        n_bad++;
        $display("FAIL rand_lookup pc=%h got %h/%b want %h/%b",
                 pc_i, next_pc_o, next_taken_o, ep, et);
      end
      n_cmp++;
      if (mispredict_cnt_o !== 16'(m_cnt)) begin
        n_bad++;
        $display("FAIL rand_cnt got %0d want %0d", mispredict_cnt_o, m_cnt);
      end
      cycle();
    end
    invalidate_i = 0;
    upd(0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    upd(1, 32'h8000_0040, 1, 32'h1234_5678);
    cycle();
    upd(0, 0, 0, 0);
    pc_i = 32'h8000_0040;
    #1;
    n_cmp++;
    if (next_pc_o !== 32'h1234_5678 || next_taken_o !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_areset got %h/%b want 12345678/1",
               next_pc_o, next_taken_o);
    end
    #1;
    n_rst_i = 1'b0;
    m_reset();
    #1;
    n_cmp++;
    if (next_pc_o !== 32'h8000_0044 || next_taken_o !== 1'b0
        || mispredict_cnt_o !== 16'd0) begin
      n_bad++;
      $display("FAIL areset got %h/%b/%0d want 80000044/0/0",
               next_pc_o, next_taken_o, mispredict_cnt_o);
    end
    #1;
    n_rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    n_cmp++;
    if (next_pc_o !== 32'h8000_0044 || next_taken_o !== 1'b0) begin
      n_bad++;
      $display("FAIL post_areset got %h/%b want 80000044/0",
               next_pc_o, next_taken_o);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 65534; k++) begin
      upd(1, 32'h0000_0100, 1, k[0] ? 32'h1000 : 32'h2000);
      @(posedge clk_i);
      #1;
    end
    n_cmp++;
    if (mispredict_cnt_o !== 16'hFFFE) begin
      n_bad++;
      $display("FAIL sat_near got %h want fffe", mispredict_cnt_o);
    end
    for (int k = 0; k < 6; k++) begin
      upd(1, 32'h0000_0100, 1, k[0] ? 32'h2000 : 32'h1000);
      @(posedge clk_i);
      #1;
    end
    upd(0, 0, 0, 0);
    n_cmp++;
    if (mispredict_cnt_o !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL sat_hold got %h want ffff", mispredict_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_train();
    test_not_taken();
    test_alias();
    test_same_cycle();
    test_wrap();
    test_random();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
